processador_v2: RTL and testbench

- Minimal 16-bit multicycle processor with register file r0..r7, accumulator A, ALU result register G and instruction register IR, all on one shared 16-bit bus.
- Instructions arrive on iin; nothing is fetched from memory.
- Every instruction takes exactly 4 clock cycles (T0..T3). The bus value is exported for observation.
- Top-level of the processor subsystem; it is driven directly by the bench or by an instruction source.

---
 rtl/processador_v2_pkg.sv | 38 +++
 rtl/processador_v2_if.sv | 19 +
 rtl/processador_alu.sv | 24 ++
 rtl/processador_v2.sv | 146 ++++++++++++++
 tb/tb_processador_v2.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/processador_v2_pkg.sv
// Shared definitions for the processador_v2 multicycle processor:
// opcode encodings, instruction step enum and bus source selection.
package processador_v2_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 8;

    localparam logic [3:0] OP_MV  = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_MVI = 4'b1010;
    localparam logic [3:0] OP_NOP = 4'b1000;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    typedef enum logic [2:0] {
        SEL_IIN  = 3'd0,
        SEL_IMM  = 3'd1,
        SEL_REG  = 3'd2,
        SEL_G    = 3'd3,
        SEL_ZERO = 3'd4
    } bus_sel_t;

    // True for the opcodes that go through the A -> G -> rX ALU sequence.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/processador_v2_if.sv
// Instruction input and observed shared bus of processador_v2.
interface processador_v2_if;

    logic [15:0] iin;
    logic [15:0] bus;

    // Instruction source / observer side
    modport master (
        output iin,
        input  bus
    );

    // Processor side
    modport slave (
        input  iin,
        output bus
    );

endinterface

// File: rtl/processador_alu.sv
// 16-bit combinational ALU; arithmetic wraps modulo 2^16, no flags.
module processador_alu
    import processador_v2_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic [3:0]  i_op,
    output logic [15:0] o_result
);

    // Operation select; unused opcodes produce zero
    always_comb begin
        o_result = '0;
        case (i_op)
            OP_AND:  o_result = i_a & i_b;
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/processador_v2.sv
// Minimal 16-bit multicycle processor: r0..r7, A, G and IR share one bus.
// Every instruction takes four steps T0..T3; decode uses IR only.
module processador_v2
    import processador_v2_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    processador_v2_if.slave  bif
);

    step_t       r_step;
    step_t       w_step_next;

    logic [15:0] r_ir;
    logic [15:0] r_a;
    logic [15:0] r_g;
    logic [15:0] r_regs [NREGS];

    logic [3:0]  w_op;
    logic [2:0]  w_rx;
    logic [2:0]  w_ry;
    logic [15:0] w_imm;
    logic        w_alu_op;

    bus_sel_t    w_sel;
    logic [2:0]  w_rd_idx;
    logic        w_ir_we;
    logic        w_a_we;
    logic        w_g_we;
    logic        w_rf_we;

    logic [15:0] w_bus;
    logic [15:0] w_alu_result;

    assign w_op     = r_ir[15:12];
    assign w_rx     = r_ir[11:9];
    assign w_ry     = r_ir[8:6];
    assign w_imm    = {7'b0, r_ir[8:0]};
    assign w_alu_op = is_alu_op(w_op);

    processador_alu u_alu (
        .i_a      (r_a),
        .i_b      (w_bus),
        .i_op     (w_op),
        .o_result (w_alu_result)
    );

    // Step register: free-running T0..T3, reset forces T0
    always_ff @(posedge clock) begin
        if (resetn) begin
            r_step <= T0;
        end else begin
            r_step <= w_step_next;
        end
    end

    // Next step: unconditional four-step cadence
    always_comb begin
        w_step_next = T0;
        case (r_step)
            T0:      w_step_next = T1;
            T1:      w_step_next = T2;
            T2:      w_step_next = T3;
            T3:      w_step_next = T0;
            default: w_step_next = T0;
        endcase
    end

    // Control decode: bus source and write enables per step; reset forces an idle zero bus
    always_comb begin
        w_sel    = SEL_ZERO;
        w_rd_idx = '0;
        w_ir_we  = 1'b0;
        w_a_we   = 1'b0;
        w_g_we   = 1'b0;
        w_rf_we  = 1'b0;
        if (!resetn) begin
            case (r_step)
                T0: begin
                    w_sel   = SEL_IIN;
                    w_ir_we = 1'b1;
                end
                T1: begin
                    if (w_op == OP_MV) begin
                        w_sel    = SEL_REG;
                        w_rd_idx = w_ry;
                        w_rf_we  = 1'b1;
                    end else if (w_op == OP_MVI) begin
                        w_sel   = SEL_IMM;
                        w_rf_we = 1'b1;
                    end else if (w_alu_op) begin
                        w_sel    = SEL_REG;
                        w_rd_idx = w_rx;
                        w_a_we   = 1'b1;
                    end
                end
                T2: begin
                    if (w_alu_op) begin
                        w_sel    = SEL_REG;
                        w_rd_idx = w_ry;
                        w_g_we   = 1'b1;
                    end
                end
                T3: begin
                    if (w_alu_op) begin
                        w_sel   = SEL_G;
                        w_rf_we = 1'b1;
                    end
                end
                default: w_sel = SEL_ZERO;
            endcase
        end
    end

    // Shared bus mux: one source per step, zero when nothing drives it
    always_comb begin
        w_bus = '0;
        case (w_sel)
            SEL_IIN:  w_bus = bif.iin;
            SEL_IMM:  w_bus = w_imm;
            SEL_REG:  w_bus = r_regs[w_rd_idx];
            SEL_G:    w_bus = r_g;
            default:  w_bus = '0;
        endcase
    end

    assign bif.bus = w_bus;

    // Datapath registers: every register loads from the bus except G, which takes the ALU result
    always_ff @(posedge clock) begin
        if (resetn) begin
            r_ir <= '0;
            r_a  <= '0;
            r_g  <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_ir_we) r_ir <= w_bus;
            if (w_a_we)  r_a  <= w_bus;
            if (w_g_we)  r_g  <= w_alu_result;
            if (w_rf_we) r_regs[w_rx] <= w_bus;
        end
    end

endmodule

// File: tb/tb_processador_v2.sv
// Self-checking bench for processador_v2: a reference model pushes the
// expected bus value of each step to a queue; each step pops and compares.
module tb_processador_v2;

    logic clock = 1'b0;
    logic resetn;

    processador_v2_if bif ();

    processador_v2 dut (
        .clock  (clock),
        .resetn (resetn),
        .bif    (bif)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q [$];
    logic [15:0] m_r [8];

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    endtask

    // Reference model: push the four expected bus values and update m_r
    task automatic push_expect(input logic [15:0] instr);
        logic [3:0]  op;
        logic [2:0]  x;
        logic [2:0]  y;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] g;
        op = instr[15:12];
        x  = instr[11:9];
        y  = instr[8:6];
        exp_q.push_back(instr);
        case (op)
            4'b0000: begin
                exp_q.push_back(m_r[y]);
                m_r[x] = m_r[y];
                exp_q.push_back(16'h0000);
                exp_q.push_back(16'h0000);
            end
            4'b1010: begin
                exp_q.push_back({7'b0, instr[8:0]});
                m_r[x] = {7'b0, instr[8:0]};
                exp_q.push_back(16'h0000);
                exp_q.push_back(16'h0000);
            end
            4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
                a = m_r[x];
                b = m_r[y];
                case (op)
                    4'b0001: g = a & b;
                    4'b0010: g = a + b;
                    4'b0011: g = a - b;
                    4'b0100: g = a | b;
                    default: g = a ^ b;
                endcase
                exp_q.push_back(a);
                exp_q.push_back(b);
                exp_q.push_back(g);
                m_r[x] = g;
            end
            default: begin
                exp_q.push_back(16'h0000);
                exp_q.push_back(16'h0000);
                exp_q.push_back(16'h0000);
            end
        endcase
    endtask

    // Drive one instruction from the start of T0 and check nsteps steps.
    // iin is scrambled after T0 so decode must rely on IR.
    task automatic run_instr(input logic [15:0] instr, input int nsteps, input string tag);
        logic [15:0] e;
        bif.iin = instr;
        push_expect(instr);
        for (int s = 0; s < nsteps; s++) begin
            @(negedge clock);
            if (exp_q.size() == 0) begin
                check_val($sformatf("%s.T%0d.queue_empty", tag, s), 16'h0001, 16'h0000);
            end else begin
                e = exp_q.pop_front();
                check_val($sformatf("%s.T%0d", tag, s), bif.bus, e);
            end
            if (s < nsteps - 1 || nsteps == 4) begin
                @(posedge clock);
                #1;
                if (s < 3) bif.iin = 16'($urandom);
            end
        end
        exp_q.delete();
    endtask

    function automatic logic [15:0] mv_self(input int unsigned k);
        logic [2:0] r;
        r = 3'(k);
        return {4'b0000, r, r, 6'b000000};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        resetn  = 1'b1;
        bif.iin = 16'hA01C;
        repeat (2) begin
            @(negedge clock);
            check_val("reset_bus", bif.bus, 16'h0000);
        end
        @(posedge clock);
        #1;
        resetn = 1'b0;

        run_instr(16'hA01C, 4, "mvi_r0");
        for (int unsigned k = 0; k < 8; k++) begin
            run_instr(mv_self(k), 4, $sformatf("peek_r%0d", k));
        end

        run_instr(16'hA40A, 4, "mvi_r2");
        run_instr(16'h2080, 4, "add_r0_r2");
        run_instr(16'h8000, 4, "nop");
        run_instr(mv_self(0), 4, "peek_r0_after_nop");
        run_instr(mv_self(2), 4, "peek_r2_after_nop");

        run_instr(16'hA201, 4, "mvi_r1_1");
        run_instr(16'h3640, 4, "sub_r3_r1");
        run_instr(16'h26C0, 4, "add_r3_r3_wrap");
        run_instr(16'h2240, 4, "add_r1_r1_double");
        run_instr(16'hAB55, 4, "mvi_r5");
        run_instr(16'h1A00, 4, "and_r5_r0");
        run_instr(16'h4D40, 4, "or_r6_r5");
        run_instr(16'h5CC0, 4, "xor_r6_r3");
        run_instr(16'h0E80, 4, "mv_r7_r2");
        run_instr(16'hF123, 4, "undef_op_F");
        run_instr(16'h6FFF, 4, "undef_op_6");
        for (int unsigned k = 0; k < 8; k++) begin
            run_instr(mv_self(k), 4, $sformatf("final_r%0d", k));
        end

        run_instr(16'h2080, 3, "add_abort");
        resetn = 1'b1;
        #1;
        check_val("mid_reset_bus", bif.bus, 16'h0000);
        @(posedge clock);
        #1;
        resetn = 1'b0;
        model_reset();
        run_instr(mv_self(0), 4, "after_abort_r0");
        run_instr(mv_self(2), 4, "after_abort_r2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
